// File: rtl/mmio_uart_tx.sv
// MMIO UART transmitter: byte FIFO feeding an 8N1 serialiser, LSB first; write-to-start latency 1 cycle.
// A push into a full FIFO drops the byte and sets sticky overflow; even parity when UART_TX_PARITY_EN is defined.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  input  logic [3:0]  data_wenable,
  output logic [31:0] data_rdata,
  output logic        sel,
  output logic        uart_tx
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
`ifdef UART_TX_PARITY_EN
  localparam logic PAR_EN = 1'b1;
`else
  localparam logic PAR_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t          state;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic            overflow;
  logic [15:0]     div;
  logic [15:0]     baud_cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shreg;

  logic [1:0]  word;
  logic        wr_txdata, wr_clr, wr_div_lo, wr_div_hi;
  logic        empty, full, baud_zero, pop, push, busy;
  logic [15:0] div_m1;
  logic        unused;

  assign sel       = (data_addr[31:4] == BASE_ADDR[31:4]);
  assign word      = data_addr[3:2];
  assign wr_txdata = sel && (word == 2'd0) && data_wenable[0];
  assign wr_clr    = sel && (word == 2'd1) && data_wenable[0] && data_wdata[2];
  assign wr_div_lo = sel && (word == 2'd2) && data_wenable[0];
  assign wr_div_hi = sel && (word == 2'd2) && data_wenable[1];

  assign empty     = (count == '0);
  assign full      = (count == CW'(FIFO_DEPTH));
  assign baud_zero = (baud_cnt == 16'd0);
  // The serialiser only takes a byte at a frame boundary, so a pop can free the slot a same-edge push needs.
  assign pop       = !empty && ((state == S_IDLE) || ((state == S_STOP) && baud_zero));
  assign push      = wr_txdata && (!full || pop);
  assign busy      = !empty || (state != S_IDLE);
  assign div_m1    = (div == 16'd0) ? 16'd0 : div - 16'd1;
  assign unused    = ^{data_wdata[31:16], data_addr[1:0], data_wenable[3:2]};

  always_ff @(posedge clk) begin
    if (rst_n && push) mem[wr_ptr] <= data_wdata[7:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      div      <= DEFAULT_DIV;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
      if (wr_txdata && !push) overflow <= 1'b1;
      else if (wr_clr)        overflow <= 1'b0;
      if (wr_div_lo) div[7:0]  <= data_wdata[7:0];
      if (wr_div_hi) div[15:8] <= data_wdata[15:8];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      uart_tx  <= 1'b1;
      baud_cnt <= 16'd0;
      bit_idx  <= 3'd0;
      shreg    <= 8'd0;
    end else begin
      case (state)
        S_IDLE: begin
          uart_tx <= 1'b1;
          if (pop) begin
            shreg    <= mem[rd_ptr];
            state    <= S_START;
            uart_tx  <= 1'b0;
            baud_cnt <= div_m1;
          end
        end
        S_START: begin
          if (baud_zero) begin
            state    <= S_DATA;
            bit_idx  <= 3'd0;
            uart_tx  <= shreg[0];
            baud_cnt <= div_m1;
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        S_DATA: begin
          if (baud_zero) begin
            baud_cnt <= div_m1;
            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state   <= S_PARITY;
              uart_tx <= ^shreg;
`else
              state   <= S_STOP;
              uart_tx <= 1'b1;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
              uart_tx <= shreg[bit_idx + 3'd1];
            end
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (baud_zero) begin
            state    <= S_STOP;
            uart_tx  <= 1'b1;
            baud_cnt <= div_m1;
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
`endif
        S_STOP: begin
          if (baud_zero) begin
            if (pop) begin
              shreg    <= mem[rd_ptr];
              state    <= S_START;
              uart_tx  <= 1'b0;
              baud_cnt <= div_m1;
            end else begin
              state    <= S_IDLE;
              uart_tx  <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        default: begin
          state   <= S_IDLE;
          uart_tx <= 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    data_rdata = 32'd0;
    if (sel) begin
      case (word)
        2'd1:    data_rdata = {16'd0, 8'(count), 4'd0, PAR_EN, overflow, full, busy};
        2'd2:    data_rdata = {16'd0, div};
        default: data_rdata = 32'd0;
      endcase
    end
  end

endmodule
